chunk_packer: RTL
=================

CHUNK_PACKER -- requirements
Module: chunk_packer

Interface
REQ-001 SHALL have parameter P_LOG, default 4, meaning log2 of records per output block.
REQ-002 SHALL have parameter IN_LOG, default 2, meaning log2 of records per input beat; IN_LOG <= P_LOG.
REQ-003 SHALL have parameter DATW, default 64, meaning record width (payload + key).
REQ-004 SHALL have parameter KEYW, default 32, meaning key width; key occupies record bits [KEYW-1:0].
REQ-005 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port DIN  input  DATW<<IN_LOG  input beat; record i at bits [DATW*(i+1)-1 : DATW*i].
REQ-008 SHALL have port DINEN  input  1  DIN valid this cycle.
REQ-009 SHALL have port FLUSH  input  1  close the current partial block with padding.
REQ-010 SHALL have port DOT  output  DATW<<P_LOG  assembled block for the downstream sorting network; record j at bits [DATW*(j+1)-1 : DATW*j].
REQ-011 SHALL have port DOTEN  output  1  DOT valid, one-cycle pulse per block.
REQ-012 SHALL have port PADCNT  output  P_LOG+1  number of pad records in the block on DOT; valid when DOTEN=1.

Function
REQ-013 SHALL hold a beat counter CNT ranging 0..BEATS-1, BEATS = 1<<(P_LOG-IN_LOG); CNT is the only control state.
REQ-014 SHALL, on DINEN=1, write the DIN records into block slots CNT*(1<<IN_LOG) .. CNT*(1<<IN_LOG)+(1<<IN_LOG)-1 and then increment CNT.
REQ-015 SHALL, on DINEN=1 with CNT=BEATS-1, register the completed block on DOT with DOTEN=1 and PADCNT=0 in the next cycle, and wrap CNT to 0.
REQ-016 SHALL therefore have a latency of exactly 1 cycle from the last beat's DINEN to DOTEN.
REQ-017 SHALL, on FLUSH=1 with DINEN=0 and CNT>0, emit the partial block next cycle with slots >= CNT*(1<<IN_LOG) filled by pad records, PADCNT=(BEATS-CNT)<<IN_LOG, and set CNT to 0.
REQ-018 SHALL define a pad record as key all-ones (KEYW bits) and payload all-zeros, so that unsigned ascending sorting places pads last.
REQ-019 SHALL, on FLUSH=1 with DINEN=1, first include the beat; if that beat completes the block, behave exactly as REQ-015 (no extra output); otherwise, pad from slot (CNT+1)*(1<<IN_LOG) onwards and emit next cycle.
REQ-020 SHALL ignore FLUSH when CNT=0 and DINEN=0: no DOTEN, CNT unchanged.
REQ-021 SHALL accept a beat on every cycle with no back-pressure; consecutive blocks may be emitted on DOTEN pulses exactly BEATS cycles apart.
REQ-022 SHALL hold DOT and PADCNT at their last emitted values while DOTEN=0.
REQ-023 SHALL not let stale slot data of a previous block appear in a flushed block (padded slots always overwritten).

Reset
REQ-024 SHALL, while RST=1, force CNT=0, DOTEN=0, DOT=0, PADCNT=0; DINEN and FLUSH ignored.
REQ-025 SHALL discard any partial block held when RST is asserted mid-fill; no DOTEN for it after reset release.

Structure
REQ-026 SHALL take P_LOG, IN_LOG, DATW, KEYW and pad-key constant from the shared sort configuration defines used by the sorting-network stages.
REQ-027 SHALL be a single module with no sub-modules; slot writes are a generate loop over BEATS.

Verification (P_LOG=4, IN_LOG=2, DATW=64, KEYW=32)
REQ-028 SHALL cover: 4 consecutive beats, records keyed 0..15 -> one DOTEN in cycle after 4th beat, DOT slot j key=j, PADCNT=0.
REQ-029 SHALL cover: 2 beats then FLUSH alone -> DOTEN next cycle, slots 8..15 key=0xFFFFFFFF payload=0, PADCNT=8.
REQ-030 SHALL cover: 3 beats, 4th beat with FLUSH=1 same cycle -> single DOTEN, PADCNT=0, no second pulse.
REQ-031 SHALL cover: FLUSH with CNT=0 and DINEN=0 -> no DOTEN; next 4 beats -> normal block.
REQ-032 SHALL cover: 2 beats, RST for 1 cycle, then 4 beats -> exactly one DOTEN, containing only the post-reset records.
REQ-033 SHALL cover: 12 back-to-back beats -> 3 DOTEN pulses spaced 4 cycles apart, contents in input order.

Source files
------------

// File: rtl/chunk_packer_pkg.sv
// chunk_packer_pkg: shared sort configuration used by the packer and the sorting-network stages.
package chunk_packer_pkg;
    localparam int SORT_P_LOG  = 4;
    localparam int SORT_IN_LOG = 2;
    localparam int SORT_DATW   = 64;
    localparam int SORT_KEYW   = 32;
endpackage

// File: rtl/chunk_packer_if.sv
// chunk_packer_if: input beat stream and assembled block output of the chunk packer.
interface chunk_packer_if import chunk_packer_pkg::*; #(
    parameter int P_LOG  = SORT_P_LOG,
    parameter int IN_LOG = SORT_IN_LOG,
    parameter int DATW   = SORT_DATW
);
    logic [(DATW<<IN_LOG)-1:0] DIN;
    logic                      DINEN;
    logic                      FLUSH;
    logic [(DATW<<P_LOG)-1:0]  DOT;
    logic                      DOTEN;
    logic [P_LOG:0]            PADCNT;
    modport master (output DIN, DINEN, FLUSH, input DOT, DOTEN, PADCNT);
    modport slave  (input DIN, DINEN, FLUSH, output DOT, DOTEN, PADCNT);
endinterface

// File: rtl/chunk_packer.sv
// chunk_packer: gathers input beats into fixed-size blocks for the sorting network,
// padding partial blocks on flush with max-key records so they sort last.
module chunk_packer import chunk_packer_pkg::*; #(
    parameter int P_LOG  = SORT_P_LOG,
    parameter int IN_LOG = SORT_IN_LOG,
    parameter int DATW   = SORT_DATW,
    parameter int KEYW   = SORT_KEYW
) (
    input logic         CLK,
    input logic         RST,
    chunk_packer_if.slave bus
);
    localparam int R     = 1 << IN_LOG;
    localparam int BEATS = 1 << (P_LOG - IN_LOG);
    localparam int BW    = DATW * R;
    localparam int CW    = P_LOG > IN_LOG ? P_LOG - IN_LOG : 1;
    localparam logic [DATW-1:0] PAD_REC  = DATW'({KEYW{1'b1}});
    localparam logic [BW-1:0]   PAD_BEAT = {R{PAD_REC}};
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [CW:0]                fill;
    logic                       last, emit, doten_q;
    logic [(DATW<<P_LOG)-1:0]   dot_d, dot_q;
    logic [P_LOG:0]             padcnt_d, padcnt_q;
    // fill = first beat slot not covered by data once this cycle's beat is included
    always_comb begin
        last     = bus.DINEN && cnt_q == CW'(BEATS - 1);
        emit     = last || (bus.FLUSH && (bus.DINEN || cnt_q != '0));
        fill     = {1'b0, cnt_q} + (CW+1)'(bus.DINEN);
        cnt_d    = emit ? '0 : cnt_q + CW'(bus.DINEN);
        padcnt_d = (P_LOG+1)'((BEATS - int'(fill)) << IN_LOG);
    end
    for (genvar b = 0; b < BEATS; b++) begin : g_slot
        logic          wr;
        logic [BW-1:0] slot_q;
        assign wr = bus.DINEN && cnt_q == CW'(b);
        assign dot_d[b*BW +: BW] = wr ? bus.DIN : ((CW+1)'(b) >= fill ? PAD_BEAT : slot_q);
        always_ff @(posedge CLK)
            if (wr) slot_q <= bus.DIN;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            doten_q  <= 1'b0;
            dot_q    <= '0;
            padcnt_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            doten_q <= emit;
            if (emit) begin
                dot_q    <= dot_d;
                padcnt_q <= padcnt_d;
            end
        end
    end
    assign bus.DOT    = dot_q;
    assign bus.DOTEN  = doten_q;
    assign bus.PADCNT = padcnt_q;
endmodule
